sram_arbiter: RTL
=================

# sram_arbiter

Shares the single external SRAM (18-bit address, 16-bit data, asynchronous, active-low strobes) between two requesters: the display scan path, which reads one grid cell per access, and the game update engine, which performs reads, writes and locked read-modify-write sequences. It sits between those two engines and the SRAM pins, and it alone drives `sram_addr`, `sram_dq`, `sram_we_n`, `sram_oe_n` and `sram_ce_n`. Display requests have priority. A starvation counter guarantees update progress.

## Interface
- `ADDR_W`, 18: SRAM address width.
- `DATA_W`, 16: SRAM data width.
- `UPD_STARVE_MAX`, 8: number of consecutive display grants, while `upd_req` is pending, after which the update engine is granted. Legal range 1..255.

- `clk_25_2` in 1: the single clock, 25.2 MHz pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `disp_req` in 1: display read request. Held with `disp_addr` stable until `disp_gnt`.
- `disp_addr` in ADDR_W: display read address.
- `disp_gnt` out 1: one-cycle pulse; request accepted.
- `disp_rvalid` out 1: one-cycle pulse; `disp_rdata` valid.
- `disp_rdata` out DATA_W: display read data, held until the next display read.
- `upd_req` in 1: update request. Held with its qualifiers stable until `upd_gnt`.
- `upd_we` in 1: 1 = write, 0 = read.
- `upd_lock` in 1: sampled with the request; keeps the bus reserved for the update engine after this access.
- `upd_addr` in ADDR_W: update address.
- `upd_wdata` in DATA_W: update write data.
- `upd_gnt` out 1: one-cycle pulse; update request accepted.
- `upd_rvalid` out 1: one-cycle pulse; `upd_rdata` valid (reads only).
- `upd_rdata` out DATA_W: update read data.
- `sram_addr` out ADDR_W: SRAM address.
- `sram_dq` inout DATA_W: SRAM data bus.
- `sram_we_n` out 1: SRAM write strobe, active low.
- `sram_oe_n` out 1: SRAM output enable, active low.
- `sram_ce_n` out 1: SRAM chip enable, active low.

## Operation
- State machine states: IDLE, RD (read setup), RD_CAP (read capture), WR (write strobe), WR_REC (write recovery).
- Every access is exactly 2 cycles: read is RD then RD_CAP; write is WR then WR_REC.
- Arbitration slots: states IDLE, RD_CAP and WR_REC. Back-to-back accesses need no idle cycle.
- Arbitration order at each slot:
  1. Lock: if `lock_owner` is set, only `upd_req` is eligible.
  2. Starvation: else if `starve_cnt == UPD_STARVE_MAX` and `upd_req`, grant update.
  3. Display priority: else if `disp_req`, grant display.
  4. Else if `upd_req`, grant update.
  5. Else go to IDLE.
- `starve_cnt` (8-bit):
  - increments on each display grant while `upd_req` is high;
  - clears on any update grant;
  - saturates at `UPD_STARVE_MAX`.
- On grant, the address, `upd_we` and `upd_wdata` are registered. The selected requester's `gnt` pulses in the following cycle.
- `lock_owner`:
  - set by an update grant carrying `upd_lock = 1`;
  - cleared by an update grant carrying `upd_lock = 0`.
  - While set with no `upd_req`, the FSM idles and display requests wait.
- Bus pins per state:
  - RD: `sram_ce_n = 0`, `sram_oe_n = 0`, `sram_dq` high-Z.
  - RD_CAP: same pins as RD; `sram_dq` is sampled into the requester's `rdata` at the end of RD_CAP.
  - WR: `sram_ce_n = 0`, `sram_we_n = 0`, `sram_dq` driven with write data.
  - WR_REC: `sram_we_n = 1`, `sram_dq` still driven, `sram_addr` held.
  - IDLE: `sram_ce_n = 1`, `sram_oe_n = 1`, `sram_we_n = 1`, `sram_dq` high-Z, `sram_addr` holds its last value.
- `sram_oe_n` low and `sram_dq` driven are never true in the same cycle.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - `sram_ce_n`, `sram_oe_n`, `sram_we_n` = 1.
  - `sram_dq` high-Z.
  - `sram_addr`, `disp_rdata`, `upd_rdata` = 0.
  - All `gnt` and `rvalid` outputs = 0.
  - State IDLE, `starve_cnt` = 0, `lock_owner` = 0.
- Reset during WR deasserts `sram_we_n` immediately. The partial write is accepted as corrupt.
- Arbitration edge E0 → `gnt` high during E0..E1.
- Read latency: `rvalid` high during E2..E3, with `rdata` stable from E2 onward. This is 2 cycles after `gnt`.
- Requesters must update `req` and qualifiers by E1. Because the next slot is E2, a held request is never granted twice.
- Throughput: 1 access per 2 cycles, 12.6 M accesses/s.
- Simultaneous `disp_req` and `upd_req` with `starve_cnt < UPD_STARVE_MAX` → display is granted.

## Structure
- Package `snake_pkg`:
  - FSM state enum;
  - `SRAM_ADDR_W` and `SRAM_DATA_W`;
  - `BORDER_VALUE` (16'hFFFF) and `OBJECTIVE_VALUE` (16'hFFFE), shared with the game logic.
- Sub-module `sram_phy`: output registers for address and strobes, `dq` output-enable register, and the tri-state driver. The arbiter FSM and counters live in `sram_arbiter`.

## Test plan
- Reset release, then `disp_req` with `disp_addr = 18'h00C4`, SRAM model holding 16'hFFFF → `disp_gnt` 1 cycle later; `disp_rvalid` 2 cycles after that with `disp_rdata = 16'hFFFF`; `sram_we_n` stays 1 throughout.
- Update write `upd_addr = 18'h0083`, `upd_wdata = 16'h0001` → `sram_we_n` low for exactly 1 cycle; `sram_dq` driven in WR and WR_REC only; a subsequent display read of `18'h0083` returns 16'h0001.
- `disp_req` held continuously and `upd_req` held, `UPD_STARVE_MAX = 8` → 8 display grants, then 1 update grant, with `starve_cnt` back to 0.
- Locked RMW: update read with `upd_lock = 1` while `disp_req` is high → no `disp_gnt` until the following update write with `upd_lock = 0` is granted; `disp_gnt` arrives at the next slot.
- `rst_n` pulled low during WR → `sram_we_n` = 1 and `sram_dq` high-Z within the same cycle; after release, state is IDLE and there are no `gnt` or `rvalid` pulses.
- Checker throughout all tests: `sram_oe_n == 0` never coincides with `sram_dq` driven.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: SRAM geometry, grid cell codes and
// the SRAM arbiter state encoding.
package snake_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    localparam logic [SRAM_DATA_W-1:0] BORDER_VALUE    = 16'hFFFF;
    localparam logic [SRAM_DATA_W-1:0] OBJECTIVE_VALUE = 16'hFFFE;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_CAP,
        WR,
        WR_REC
    } arb_state_t;

endpackage

// File: rtl/sram_phy.sv
// SRAM pin stage: registered address/strobes and the dq tri-state driver,
// steered by the arbiter's next state so pins line up with the FSM state.
module sram_phy
    import snake_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              clk_25_2,
    input  logic              rst_n,
    input  arb_state_t        next_state,
    input  logic              addr_ld,
    input  logic [ADDR_W-1:0] addr_d,
    input  logic [DATA_W-1:0] wdata_d,
    output logic [DATA_W-1:0] dq_in,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_ce_n
);

    logic              dq_oe;
    logic [DATA_W-1:0] wdata_q;

    always_ff @(posedge clk_25_2 or negedge rst_n) begin
        if (!rst_n) begin
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            dq_oe     <= 1'b0;
            sram_addr <= '0;
        end else begin
            sram_ce_n <= (next_state == IDLE);
            sram_oe_n <= !(next_state inside {RD, RD_CAP});
            sram_we_n <= (next_state != WR);
            dq_oe     <= (next_state inside {WR, WR_REC});
            if (addr_ld) begin
                sram_addr <= addr_d;
            end
        end
    end

    // Write data only matters while dq_oe is set, so it carries no reset.
    always_ff @(posedge clk_25_2) begin
        if (addr_ld) begin
            wdata_q <= wdata_d;
        end
    end

    assign sram_dq = dq_oe ? wdata_q : 'z;
    assign dq_in   = sram_dq;

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter: display reads have priority, a starvation
// counter forces update progress, and locked update sequences own the bus.
module sram_arbiter
    import snake_pkg::*;
#(
    parameter int          ADDR_W         = SRAM_ADDR_W,
    parameter int          DATA_W         = SRAM_DATA_W,
    parameter int unsigned UPD_STARVE_MAX = 8
) (
    input  logic              clk_25_2,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              upd_req,
    input  logic              upd_we,
    input  logic              upd_lock,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DATA_W-1:0] upd_wdata,
    output logic              upd_gnt,
    output logic              upd_rvalid,
    output logic [DATA_W-1:0] upd_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              sram_ce_n
);

    localparam logic [7:0] STARVE_MAX = 8'(UPD_STARVE_MAX);

    arb_state_t        state_q, state_d;
    logic              grant_disp, grant_upd;
    logic              addr_ld;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] dq_in;
    logic [7:0]        starve_cnt;
    logic              lock_owner;
    logic              acc_disp;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
        return (v >= lim) ? lim : v + 8'd1;
    endfunction

    // RD and WR always advance; every other state is an arbitration slot.
    always_comb begin
        grant_disp = 1'b0;
        grant_upd  = 1'b0;
        state_d    = IDLE;
        case (state_q)
            RD: state_d = RD_CAP;
            WR: state_d = WR_REC;
            default: begin
                if (lock_owner) begin
                    grant_upd = upd_req;
                end else if (starve_cnt == STARVE_MAX && upd_req) begin
                    grant_upd = 1'b1;
                end else if (disp_req) begin
                    grant_disp = 1'b1;
                end else begin
                    grant_upd = upd_req;
                end
                if (grant_disp) begin
                    state_d = RD;
                end else if (grant_upd) begin
                    state_d = upd_we ? WR : RD;
                end
            end
        endcase
    end

    assign addr_ld = grant_disp | grant_upd;
    assign addr_d  = grant_disp ? disp_addr : upd_addr;

    always_ff @(posedge clk_25_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_cnt  <= 8'd0;
            lock_owner  <= 1'b0;
            acc_disp    <= 1'b0;
            disp_gnt    <= 1'b0;
            upd_gnt     <= 1'b0;
            disp_rvalid <= 1'b0;
            upd_rvalid  <= 1'b0;
            disp_rdata  <= '0;
            upd_rdata   <= '0;
        end else begin
            state_q  <= state_d;
            disp_gnt <= grant_disp;
            upd_gnt  <= grant_upd;
            if (grant_upd) begin
                starve_cnt <= 8'd0;
                lock_owner <= upd_lock;
            end else if (grant_disp && upd_req) begin
                starve_cnt <= sat_inc(starve_cnt, STARVE_MAX);
            end
            if (addr_ld) begin
                acc_disp <= grant_disp;
            end
            disp_rvalid <= (state_q == RD_CAP) && acc_disp;
            upd_rvalid  <= (state_q == RD_CAP) && !acc_disp;
            if (state_q == RD_CAP) begin
                if (acc_disp) begin
                    disp_rdata <= dq_in;
                end else begin
                    upd_rdata <= dq_in;
                end
            end
        end
    end

    sram_phy #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_phy (
        .clk_25_2  (clk_25_2),
        .rst_n     (rst_n),
        .next_state(state_d),
        .addr_ld   (addr_ld),
        .addr_d    (addr_d),
        .wdata_d   (upd_wdata),
        .dq_in     (dq_in),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .sram_we_n (sram_we_n),
        .sram_oe_n (sram_oe_n),
        .sram_ce_n (sram_ce_n)
    );

endmodule
